// File: rtl/compressor_top.sv
// compressor_top: loads 16-byte chunks, then emits one hashed LZ77 literal/copy token per clock
module compressor_top #(
  parameter int STRINGSIZE = 350,
  parameter int TABLESIZE = 4096
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         valid,
  input  logic [15:0][7:0]             CurByte,
  output logic                         Done,
  output logic [STRINGSIZE-1:0][7:0]   compArray,
  output logic [STRINGSIZE-1:0]        controlWord
);
  localparam int AW = $clog2(STRINGSIZE);
  localparam int HW = $clog2(TABLESIZE);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, COMPRESS = 2'd2, DONE = 2'd3;
  typedef logic [STRINGSIZE-1:0][7:0] bytes_t;
  logic [1:0] state_q, state_d;
  bytes_t buf_q, buf_d, comp_q, comp_d;
  logic [STRINGSIZE-1:0] ctrl_q, ctrl_d;
  logic [15:0] wr_q, wr_d, n_q, n_d, bp_q, bp_d, cp_q, cp_d, ctl_q, ctl_d;
  logic zf_q, zf_d;
  logic [TABLESIZE-1:0] tv_q, tv_d;
  logic [11:0] tpos_q [TABLESIZE];
  logic [11:0] pos;
  logic [HW-1:0] h;
  logic [15:0] rem, off, x, prod, p;
  logic [4:0] mlen;
  logic run, is_copy, tw_en;

  function automatic logic [7:0] rd(input bytes_t b, input logic [15:0] a);
    return (a < 16'(STRINGSIZE)) ? b[a[AW-1:0]] : 8'h00;
  endfunction

  // hash the three bytes at bp, fetch the candidate position and measure the match run
  always_comb begin
    rem = n_q - bp_q;
    x = {rd(buf_q, bp_q), 8'h00} ^ {4'h0, rd(buf_q, bp_q + 16'd1), 4'h0} ^ {8'h00, rd(buf_q, bp_q + 16'd2)};
    prod = x * 16'd40543;
    h = HW'(prod >> 4);
    pos = tpos_q[h];
    off = bp_q - {4'h0, pos};
    mlen = '0;
    run = 1'b1;
    for (int i = 0; i < 18; i++) begin
      run = run && (16'(i) < rem) && (rd(buf_q, {4'h0, pos} + 16'(i)) == rd(buf_q, bp_q + 16'(i)));
      mlen = mlen + 5'(run);
    end
    is_copy = tv_q[h] && off >= 16'd1 && off <= 16'd4095 && rem >= 16'd3 && mlen >= 5'd3;
  end

  // load chunks, then emit one token per clock until the data length is consumed
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    comp_d = comp_q;
    ctrl_d = ctrl_q;
    wr_d = wr_q;
    n_d = n_q;
    zf_d = zf_q;
    bp_d = bp_q;
    cp_d = cp_q;
    ctl_d = ctl_q;
    tv_d = tv_q;
    tw_en = 1'b0;
    p = '0;
    case (state_q)
      IDLE, LOAD: begin
        if (valid) begin
          state_d = LOAD;
          wr_d = (wr_q < 16'(STRINGSIZE)) ? wr_q + 16'd16 : wr_q;
          for (int i = 0; i < 16; i++) begin
            p = wr_q + 16'(i);
            if (p < 16'(STRINGSIZE)) begin
              buf_d[p[AW-1:0]] = CurByte[i];
              zf_d = zf_d || (CurByte[i] == 8'h00);
              n_d = zf_d ? n_d : n_d + 16'd1;
            end
          end
        end else if (state_q == LOAD) begin
          state_d = COMPRESS;
          bp_d = '0;
        end
      end
      COMPRESS: begin
        if (bp_q >= n_q) state_d = DONE;
        else begin
          tw_en = rem >= 16'd3;
          if (tw_en) tv_d[h] = 1'b1;
          p = cp_q + 16'd1;
          if (is_copy) begin
            if (cp_q < 16'(STRINGSIZE)) comp_d[cp_q[AW-1:0]] = {4'(mlen - 5'd3), off[11:8]};
            if (p < 16'(STRINGSIZE)) comp_d[p[AW-1:0]] = off[7:0];
          end else if (cp_q < 16'(STRINGSIZE)) comp_d[cp_q[AW-1:0]] = rd(buf_q, bp_q);
          if (ctl_q < 16'(STRINGSIZE)) ctrl_d[ctl_q[AW-1:0]] = is_copy;
          cp_d = cp_q + (is_copy ? 16'd2 : 16'd1);
          bp_d = bp_q + (is_copy ? 16'(mlen) : 16'd1);
          ctl_d = ctl_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  // state registers, cleared immediately on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q <= '0;
      comp_q <= '0;
      ctrl_q <= '0;
      wr_q <= '0;
      n_q <= '0;
      zf_q <= 1'b0;
      bp_q <= '0;
      cp_q <= '0;
      ctl_q <= '0;
      tv_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      comp_q <= comp_d;
      ctrl_q <= ctrl_d;
      wr_q <= wr_d;
      n_q <= n_d;
      zf_q <= zf_d;
      bp_q <= bp_d;
      cp_q <= cp_d;
      ctl_q <= ctl_d;
      tv_q <= tv_d;
    end
  end

  // hash table positions need no reset because the valid flags gate them
  always_ff @(posedge clock) begin
    if (tw_en) tpos_q[h] <= bp_q[11:0];
  end

  assign Done = state_q == DONE;
  assign compArray = comp_q;
  assign controlWord = ctrl_q;
endmodule

// File: tb/tb_compressor_top.sv
// tb_compressor_top: directed and random checks of compressor_top against a reference compressor model
module tb_compressor_top;
  localparam int SS = 350;
  logic clock = 1'b0, reset = 1'b1, valid = 1'b0;
  logic [15:0][7:0] CurByte = '0;
  logic Done;
  logic [SS-1:0][7:0] compArray;
  logic [SS-1:0] controlWord;
  int total = 0, bad = 0;
  logic [7:0] data [400];
  logic [SS-1:0][7:0] exp_comp;
  logic [SS-1:0] exp_ctrl;
  int exp_t;
  logic [7:0] e5 [5];

  compressor_top #(.STRINGSIZE(SS), .TABLESIZE(4096)) dut (
    .clock(clock), .reset(reset), .valid(valid), .CurByte(CurByte),
    .Done(Done), .compArray(compArray), .controlWord(controlWord)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag);
    int k;
    k = 0;
    total++;
    assert (compArray === exp_comp) else begin
      bad++;
      for (int i = SS - 1; i >= 0; i--) if (compArray[i] !== exp_comp[i]) k = i;
      $error("FAIL %s compArray[%0d] observed=%0h expected=%0h", tag, k, compArray[k], exp_comp[k]);
    end
    total++;
    assert (controlWord === exp_ctrl) else begin
      bad++;
      $error("FAIL %s controlWord observed=%0h expected=%0h", tag, controlWord, exp_ctrl);
    end
  endtask

  task automatic model(input int chunks);
    logic [7:0] b [400];
    bit tv [4096];
    int tp [4096];
    int lim, n, bp, cp, ctl, rem, len, off, h;
    bit cpy;
    longint x;
    lim = (chunks * 16 < SS) ? chunks * 16 : SS;
    n = lim;
    for (int i = lim - 1; i >= 0; i--) if (data[i] == 8'h00) n = i;
    for (int i = 0; i < 400; i++) b[i] = (i < lim) ? data[i] : 8'h00;
    for (int i = 0; i < 4096; i++) begin tv[i] = 0; tp[i] = 0; end
    exp_comp = '0;
    exp_ctrl = '0;
    bp = 0; cp = 0; ctl = 0;
    while (bp < n) begin
      rem = n - bp;
      x = (longint'(b[bp]) << 8) ^ (longint'(b[bp+1]) << 4) ^ longint'(b[bp+2]);
      h = int'(((40543 * x) >> 4) & 'hFFF);
      off = bp - tp[h];
      len = 0;
      if (tv[h]) while (len < 18 && len < rem && b[tp[h]+len] == b[bp+len]) len++;
      cpy = tv[h] && off >= 1 && off <= 4095 && rem >= 3 && len >= 3;
      if (rem >= 3) begin tv[h] = 1; tp[h] = bp; end
      if (cpy) begin
        if (cp < SS) exp_comp[cp] = {4'(len - 3), 4'(off >> 8)};
        if (cp + 1 < SS) exp_comp[cp+1] = 8'(off);
        cp += 2;
        bp += len;
      end else begin
        if (cp < SS) exp_comp[cp] = b[bp];
        cp++;
        bp++;
      end
      if (ctl < SS) exp_ctrl[ctl] = cpy;
      ctl++;
    end
    exp_t = ctl;
  endtask

  task automatic fill_str(input string s);
    for (int i = 0; i < 400; i++) data[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  task automatic fill_rand(input int letters, input bit zero);
    for (int i = 0; i < 400; i++) data[i] = 8'h61 + 8'($urandom_range(0, letters - 1));
    if (zero) data[$urandom_range(0, 360)] = 8'h00;
  endtask

  task automatic load(input int chunks);
    for (int c = 0; c < chunks; c++) begin
      valid = 1'b1;
      for (int i = 0; i < 16; i++) CurByte[i] = data[16*c+i];
      @(posedge clock); #1;
    end
    valid = 1'b0;
    CurByte = '0;
  endtask

  task automatic run(input int chunks, input string tag);
    int cyc;
    model(chunks);
    load(chunks);
    cyc = 0;
    while (!Done && cyc < 1000) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk({tag, " cycles"}, 64'(cyc), 64'(exp_t + 2));
    chk_out(tag);
    repeat (3) begin
      valid = 1'($urandom);
      CurByte = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clock); #1;
    end
    valid = 1'b0;
    CurByte = '0;
    chk({tag, " done hold"}, 64'(Done), 64'(1));
    chk_out({tag, " hold"});
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, " rst Done"}, 64'(Done), 64'(0));
    chk({tag, " rst comp zero"}, 64'(compArray === '0), 64'(1));
    chk({tag, " rst ctrl zero"}, 64'(controlWord === '0), 64'(1));
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    chk("por Done", 64'(Done), 64'(0));
    chk("por comp zero", 64'(compArray === '0), 64'(1));
    chk("por ctrl zero", 64'(controlWord === '0), 64'(1));
    @(posedge clock); #1;
    reset = 1'b0;
    fill_str("TsIsSixteenChars");
    run(1, "sixteen");
    for (int i = 0; i < 16; i++) chk($sformatf("sixteen byte%0d", i), 64'(compArray[i]), 64'(data[i]));
    chk("sixteen ctrl", 64'(controlWord[15:0]), 64'(0));
    do_reset("abc");
    fill_str("abcabcabc");
    run(1, "abc");
    e5 = '{8'h61, 8'h62, 8'h63, 8'h30, 8'h03};
    for (int i = 0; i < 5; i++) chk($sformatf("abc byte%0d", i), 64'(compArray[i]), 64'(e5[i]));
    chk("abc ctrl", 64'(controlWord[3:0]), 64'(4'b1000));
    do_reset("aaa");
    fill_str("AAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA");
    run(2, "aaa");
    e5 = '{8'h41, 8'hF0, 8'h01, 8'hA0, 8'h12};
    for (int i = 0; i < 5; i++) chk($sformatf("aaa byte%0d", i), 64'(compArray[i]), 64'(e5[i]));
    chk("aaa ctrl", 64'(controlWord[2:0]), 64'(3'b110));
    do_reset("empty");
    fill_str("");
    run(1, "empty");
    do_reset("full");
    fill_rand(3, 0);
    run(22, "full");
    for (int t = 0; t < 8; t++) begin
      do_reset($sformatf("rand%0d", t));
      fill_rand(1 + t % 5, 1'(t % 2));
      run($urandom_range(1, 22), $sformatf("rand%0d", t));
    end
    do_reset("first");
    fill_rand(2, 0);
    run(10, "first");
    do_reset("mid");
    load(10);
    repeat (6) begin @(posedge clock); #1; end
    do_reset("midcompress");
    run(10, "reload");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/compressor_top.md
COMPRESSOR_TOP -- requirements
Module: compressor_top

Interface
REQ-001 The module SHALL have a parameter STRINGSIZE, default 350, giving the maximum input bytes and the output array depth.
REQ-002 The module SHALL have a parameter TABLESIZE, default 4096, giving the hash table entries; the hash index is log2(TABLESIZE) = 12 bits.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port valid, input, 1 bit: when high, CurByte carries a 16-byte input chunk.
REQ-007 The module SHALL have port CurByte, input, [15:0][7:0]: input chunk, where CurByte[0] is the earliest byte.
REQ-008 The module SHALL have port Done, output, 1 bit: compression complete.
REQ-009 The module SHALL have port compArray, output, [STRINGSIZE-1:0][7:0]: compressed byte stream, starting at index 0.
REQ-010 The module SHALL have port controlWord, output, [STRINGSIZE-1:0]: one flag per token, 0 = literal, 1 = copy; bit 0 is the first token.

Function
REQ-011 The module SHALL implement the states IDLE -> LOAD -> COMPRESS -> DONE.
REQ-012 IDLE SHALL go to LOAD on the first rising edge with valid=1.
REQ-013 In LOAD, on each rising edge with valid=1, chunk n SHALL be written to buffer bytes [16n +: 16]; bytes at index >= STRINGSIZE SHALL be discarded.
REQ-014 On the first edge with valid=0 in LOAD, the block SHALL enter COMPRESS with bytePtr=0.
REQ-015 The data length N SHALL be min(16 x chunks received, STRINGSIZE, index of the first 0x00 byte).
REQ-016 valid SHALL be ignored in COMPRESS and DONE.
REQ-017 COMPRESS SHALL emit exactly one token per clock at bytePtr.
REQ-018 The hash SHALL be h = ((40543 x ((b0<<8) ^ (b1<<4) ^ b2)) >> 4) & 0xFFF, where b0..b2 = buf[bytePtr..bytePtr+2].
REQ-019 Each table entry SHALL hold a 1-bit valid flag and a 12-bit position.
REQ-020 For a candidate, offset = bytePtr - entry.position.
REQ-021 The match length SHALL be the count of leading equal bytes between buf[pos..] and buf[bytePtr..], capped at 18 and at N - bytePtr.
REQ-022 A copy SHALL be emitted when the entry is valid, 1 <= offset <= 4095, N - bytePtr >= 3, and length >= 3; otherwise a literal SHALL be emitted.
REQ-023 A literal SHALL write compArray[cp] = buf[bytePtr] and controlWord[ctl] = 0, then do cp += 1, bytePtr += 1.
REQ-024 A copy SHALL write compArray[cp] = {length-3 [3:0], offset[11:8]} and compArray[cp+1] = offset[7:0], set controlWord[ctl] = 1, then do cp += 2, bytePtr += length.
REQ-025 In both cases ctl SHALL increment by 1.
REQ-026 On every token with N - bytePtr >= 3, table[h] SHALL be written with {valid=1, position=bytePtr}; no other positions are inserted.
REQ-027 The next-state bytePtr SHALL always equal the old bytePtr plus the emitted length, where a literal counts as 1.
REQ-028 When bytePtr >= N, the block SHALL enter DONE; N=0 SHALL go directly to DONE.
REQ-029 In DONE, Done=1 and all outputs SHALL hold until reset.
REQ-030 Unwritten compArray and controlWord entries SHALL remain 0.
REQ-031 Writes with cp or ctl >= STRINGSIZE SHALL be dropped.

Reset
REQ-032 While reset=1, the block SHALL be in IDLE with Done=0, compArray=0, controlWord=0, all table valid flags=0, bytePtr=cp=ctl=0, and buffer=0.
REQ-033 Assertion of reset in any state, including mid-COMPRESS, SHALL take effect immediately.
REQ-034 After reset deasserts, the block SHALL accept a new LOAD.

Verification
REQ-035 Scenario "TsIsSixteenChars" (1 chunk): expect 16 literals, compArray[0..15] = input bytes, controlWord[15:0] = 0, Done=1.
REQ-036 Scenario "abcabcabc", zero-padded: expect compArray[0..4] = 61, 62, 63, 0x30, 0x03 and controlWord[3:0] = 4'b1000.
REQ-037 Scenario 32 x 'A' (2 chunks): expect compArray[0..4] = 0x41, 0xF0, 0x01, 0xA0, 0x12 and controlWord[2:0] = 3'b110.
REQ-038 Scenario: assert reset mid-COMPRESS -> next sample all outputs = 0 and Done=0; reloading the same input SHALL give results identical to the first run.
REQ-039 Scenario: check every cycle that bytePtr advances by the emitted length, every copy has length >= 3 and offset > 0, and each token's controlWord bit matches its type.
